qch_clk_gate_ctrl: RTL and testbench

- Q-channel clock-gating controller. It is the parametrised successor to the plain `gated_clk = clk & qactive` wrapper gating.
- Aggregates NUM_DEV qactive requests and applies idle hysteresis before asking the device to stop.
- Runs the full Q-channel handshake (request/accept/deny/exit) with the device.
- Gates the device clock glitch-free through a latch-based ICG, with a DFT scan override.
- Sits between the clock source and each gated IP wrapper.

---
 rtl/qch_pkg.sv | 17 +
 rtl/qch_clk_gate_ctrl_clk_icg.sv | 21 ++
 rtl/qch_clk_gate_ctrl.sv | 151 +++++++++++++++
 tb/tb_qch_clk_gate_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/qch_pkg.sv
// Shared types for the Q-channel clock-gating controller.
// Holds the FSM state encoding (visible on q_state_out) and its width.
// Imported by qch_clk_gate_ctrl.
package qch_pkg;

  localparam int QCH_STATE_W = 3;

  typedef enum logic [QCH_STATE_W-1:0] {
    QCH_RUN      = 3'd0,
    QCH_REQUEST  = 3'd1,
    QCH_STOPPED  = 3'd2,
    QCH_WAKE     = 3'd3,
    QCH_EXIT     = 3'd4,
    QCH_CONTINUE = 3'd5
  } qch_state_e;

endpackage

// File: rtl/qch_clk_gate_ctrl_clk_icg.sv
// Glitch-free clock gate: latch open while clk_in is low, AND with clk_in.
// Ports: clk_in source clock, en_in functional enable, test_en_in scan
//   override, clk_out gated clock. Swap for a library ICG cell in synthesis.
module clk_icg (
  input  logic clk_in,
  input  logic en_in,
  input  logic test_en_in,
  output logic clk_out
);

  logic en_latch;

  // Enable only changes while clk_in is low, so the AND never sees a
  // transition during the high phase and cannot produce a runt pulse.
  always_latch begin
    if (!clk_in) en_latch <= en_in | test_en_in;
  end

  assign clk_out = clk_in & en_latch;

endmodule

// File: rtl/qch_clk_gate_ctrl.sv
// Q-channel clock-gating controller: idle hysteresis, Q-channel handshake
// and glitch-free gating of the device clock. Optional macro QCH_SYNC_EN
// adds 2-flop synchronisers on all handshake/activity inputs (+2 cycles).
// Ports: clk_in/rst_n_in, qactive_in[NUM_DEV], wake_in, qacceptn_in,
//   qdenyn_in, scan_en_in -> qreqn_out, gated_clk_out, clk_en_out,
//   q_state_out, proto_err_out (sticky until reset). All outputs registered
//   except gated_clk_out, which is clk_in through the ICG.
module qch_clk_gate_ctrl
  import qch_pkg::*;
#(
  parameter int NUM_DEV     = 2,
  parameter int HYST_CYCLES = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [NUM_DEV-1:0]     qactive_in,
  input  logic                   wake_in,
  input  logic                   qacceptn_in,
  input  logic                   qdenyn_in,
  input  logic                   scan_en_in,
  output logic                   qreqn_out,
  output logic                   gated_clk_out,
  output logic                   clk_en_out,
  output logic [QCH_STATE_W-1:0] q_state_out,
  output logic                   proto_err_out
);

  // A zero-cycle hysteresis still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (HYST_CYCLES > 0) ? $clog2(HYST_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HYST_MAX = CNT_W'(HYST_CYCLES);

  logic [NUM_DEV-1:0] qact;
  logic               wake;
  logic               acc_n;
  logic               deny_n;

`ifdef QCH_SYNC_EN
  localparam int SYNC_W = NUM_DEV + 3;
  // Active-low handshake lines reset to their idle-high level.
  localparam logic [SYNC_W-1:0] SYNC_RST = {2'b11, {(NUM_DEV + 1){1'b0}}};

  logic [SYNC_W-1:0] sync1_q;
  logic [SYNC_W-1:0] sync2_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {qacceptn_in, qdenyn_in, wake_in, qactive_in};
      sync2_q <= sync1_q;
    end
  end

  assign {acc_n, deny_n, wake, qact} = sync2_q;
`else
  assign qact   = qactive_in;
  assign wake   = wake_in;
  assign acc_n  = qacceptn_in;
  assign deny_n = qdenyn_in;
`endif

  logic qact_any;
  assign qact_any = |qact;

  qch_state_e       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             err_q,    err_d;
  logic             qreqn_q,  qreqn_d;
  logic             clk_en_q, clk_en_d;

  // State register; outputs are registered from the next state so that
  // nothing on the output side is combinational from an input.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= QCH_RUN;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      qreqn_q  <= 1'b1;
      clk_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      qreqn_q  <= qreqn_d;
      clk_en_q <= clk_en_d;
    end
  end

  // Next-state logic. The counter only runs in RUN; it is held at zero
  // everywhere else so every return to RUN starts a fresh idle window.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      QCH_RUN: begin
        // The device must not answer a request that was never made.
        if (!acc_n || !deny_n) err_d = 1'b1;
        if (qact_any) begin
          cnt_d = '0;
        end else if (cnt_q == HYST_MAX) begin
          state_d = QCH_REQUEST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      QCH_REQUEST: begin
        // Deny takes priority; accept and deny together is illegal.
        if (!deny_n) begin
          state_d = QCH_CONTINUE;
          if (!acc_n) err_d = 1'b1;
        end else if (!acc_n) begin
          state_d = QCH_STOPPED;
        end
      end
      QCH_STOPPED:  if (qact_any || wake) state_d = QCH_WAKE;
      QCH_WAKE:     state_d = QCH_EXIT;
      QCH_EXIT:     if (acc_n) state_d = QCH_RUN;
      QCH_CONTINUE: if (deny_n) state_d = QCH_RUN;
      default:      state_d = QCH_RUN;
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    qreqn_d  = 1'b1;
    clk_en_d = 1'b1;
    unique case (state_d)
      QCH_REQUEST, QCH_WAKE: qreqn_d = 1'b0;
      QCH_STOPPED: begin
        qreqn_d  = 1'b0;
        clk_en_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign qreqn_out     = qreqn_q;
  assign clk_en_out    = clk_en_q;
  assign q_state_out   = state_q;
  assign proto_err_out = err_q;

  clk_icg u_icg (
    .clk_in     (clk_in),
    .en_in      (clk_en_q),
    .test_en_in (scan_en_in),
    .clk_out    (gated_clk_out)
  );

endmodule

// File: tb/tb_qch_clk_gate_ctrl.sv
// Bench for qch_clk_gate_ctrl: directed vector table, hand sequences for
// reset/scan corners, then randomized stimulus against a behavioural model.
module tb_qch_clk_gate_ctrl;

  localparam int NUM_DEV = 2;
  localparam int HYST    = 8;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b1;
  logic [NUM_DEV-1:0] qactive = '0;
  logic               wake   = 1'b0;
  logic               acc_n  = 1'b1;
  logic               deny_n = 1'b1;
  logic               scan   = 1'b0;

  wire       qreqn;
  wire       gclk;
  wire       clk_en;
  wire [2:0] qstate;
  wire       perr;

  always #5 clk = ~clk;

  qch_clk_gate_ctrl #(.NUM_DEV(NUM_DEV), .HYST_CYCLES(HYST)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .qactive_in    (qactive),
    .wake_in       (wake),
    .qacceptn_in   (acc_n),
    .qdenyn_in     (deny_n),
    .scan_en_in    (scan),
    .qreqn_out     (qreqn),
    .gated_clk_out (gclk),
    .clk_en_out    (clk_en),
    .q_state_out   (qstate),
    .proto_err_out (perr)
  );

  int   checks = 0;
  int   errors = 0;
  logic last_en;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // States by their published codes; m_idle counts consecutive idle RUN cycles.
  int m_state;
  int m_idle;
  bit m_err;

  function automatic void model_step(bit any, bit wk, bit an, bit dn);
    case (m_state)
      0: begin
        if (!an || !dn) m_err = 1'b1;
        if (!any && m_idle >= HYST) begin
          m_state = 1;
          m_idle  = 0;
        end else begin
          m_idle = any ? 0 : m_idle + 1;
        end
      end
      1: begin
        if (!dn) begin
          m_state = 5;
          if (!an) m_err = 1'b1;
        end else if (!an) begin
          m_state = 2;
        end
      end
      2: if (any || wk) m_state = 3;
      3: m_state = 4;
      4: if (an) begin m_state = 0; m_idle = 0; end
      5: if (dn) begin m_state = 0; m_idle = 0; end
      default: m_state = 0;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NUM_DEV-1:0] qa;
    logic               wk, an, dn, sc;
    logic [2:0]         st;
    logic               qr, en, er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, logic [NUM_DEV-1:0] qa, logic wk, logic an, logic dn,
                              logic sc, logic [2:0] st, logic qr, logic en, logic er);
    vec_t v;
    v.qa = qa; v.wk = wk; v.an = an; v.dn = dn; v.sc = sc;
    v.st = st; v.qr = qr; v.en = en; v.er = er;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  // Apply inputs, advance one edge, compare. The gated clock in the high
  // phase reflects the enable (or scan) seen during the preceding low phase.
  task automatic step(input string tag, input vec_t v);
    logic eg;
    qactive = v.qa; wake = v.wk; acc_n = v.an; deny_n = v.dn; scan = v.sc;
    eg = last_en | v.sc;
    @(posedge clk); #1;
    chk({tag, ".state"}, 8'(qstate), 8'(v.st));
    chk({tag, ".qreqn"}, 8'(qreqn),  8'(v.qr));
    chk({tag, ".clken"}, 8'(clk_en), 8'(v.en));
    chk({tag, ".perr"},  8'(perr),   8'(v.er));
    chk({tag, ".gclk"},  8'(gclk),   8'(eg));
    last_en = v.en;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_state"}, 8'(qstate), 8'd0);
    chk({tag, ".rst_qreqn"}, 8'(qreqn),  8'd1);
    chk({tag, ".rst_clken"}, 8'(clk_en), 8'd1);
    chk({tag, ".rst_perr"},  8'(perr),   8'd0);
    qactive = '0; wake = 1'b0; acc_n = 1'b1; deny_n = 1'b1; scan = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".rst_gclk_hi"}, 8'(gclk), 8'd1);
    @(negedge clk); #1;
    chk({tag, ".rst_gclk_lo"}, 8'(gclk), 8'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    last_en = 1'b1;
    m_state = 0; m_idle = 0; m_err = 1'b0;
  endtask

  initial begin
    #2;
    do_reset("init");

    // idle -> request on the 9th edge, then accept
    add(8, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    add(1, 2'b00, 0, 1, 1, 0, 3'd1, 0, 1, 0);
    add(1, 2'b00, 0, 0, 1, 0, 3'd2, 0, 0, 0);
    add(2, 2'b00, 0, 0, 1, 0, 3'd2, 0, 0, 0);
    // wake via qactive[0], exit, wait for accept release
    add(1, 2'b01, 0, 0, 1, 0, 3'd3, 0, 1, 0);
    add(1, 2'b01, 0, 0, 1, 0, 3'd4, 1, 1, 0);
    add(1, 2'b01, 0, 0, 1, 0, 3'd4, 1, 1, 0);
    add(1, 2'b01, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    // hysteresis restart: 5 idle, 1 active, then 9 more to request
    add(5, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    add(1, 2'b10, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    add(8, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    add(1, 2'b00, 0, 1, 1, 0, 3'd1, 0, 1, 0);
    // activity in REQUEST is ignored
    add(1, 2'b11, 0, 1, 1, 0, 3'd1, 0, 1, 0);
    // deny path: clock never stops
    add(2, 2'b00, 0, 1, 0, 0, 3'd5, 1, 1, 0);
    add(1, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    // accept + deny together: deny wins, sticky error
    add(8, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 0);
    add(1, 2'b00, 0, 1, 1, 0, 3'd1, 0, 1, 0);
    add(1, 2'b00, 0, 0, 0, 0, 3'd5, 1, 1, 1);
    add(1, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 1);
    // wake_in has no effect in RUN (counts as idle)
    add(1, 2'b00, 1, 1, 1, 0, 3'd0, 1, 1, 1);
    add(7, 2'b00, 0, 1, 1, 0, 3'd0, 1, 1, 1);
    add(1, 2'b00, 0, 1, 1, 0, 3'd1, 0, 1, 1);
    add(1, 2'b00, 0, 0, 1, 0, 3'd2, 0, 0, 1);
    // scan override in STOPPED: clock runs, FSM untouched
    add(1, 2'b00, 0, 0, 1, 1, 3'd2, 0, 0, 1);
    add(1, 2'b00, 0, 0, 1, 0, 3'd2, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // scan asserted mid-cycle in STOPPED: gated clock follows from the next low phase
    scan = 1'b1;
    @(negedge clk); #1;
    chk("scan.gclk_lo", 8'(gclk), 8'd0);
    @(posedge clk); #1;
    chk("scan.gclk_hi", 8'(gclk), 8'd1);
    chk("scan.state", 8'(qstate), 8'd2);
    scan = 1'b0;

    // reset while STOPPED returns to RUN immediately
    #3;
    do_reset("midop");

    // accept low while in RUN is a protocol error without a state change
    begin
      vec_t v;
      v.qa = '0; v.wk = 0; v.an = 0; v.dn = 1; v.sc = 0;
      v.st = 3'd0; v.qr = 1; v.en = 1; v.er = 1;
      step("runerr_acc", v);
    end
    do_reset("rst2");
    begin
      vec_t v;
      v.qa = '0; v.wk = 0; v.an = 1; v.dn = 0; v.sc = 0;
      v.st = 3'd0; v.qr = 1; v.en = 1; v.er = 1;
      step("runerr_deny", v);
    end

    // randomized stimulus against the reference model
    for (int seg = 0; seg < 3; seg++) begin
      #($urandom_range(1, 3));
      do_reset($sformatf("rnd%0d", seg));
      for (int i = 0; i < 600; i++) begin
        logic [NUM_DEV-1:0] qa;
        logic wk, an, dn, sc, eg, eq, ee;
        qa = ($urandom_range(0, 11) == 0) ? NUM_DEV'($urandom) : '0;
        wk = ($urandom_range(0, 15) == 0);
        an = ($urandom_range(0, 3) != 0);
        dn = ($urandom_range(0, 9) != 0);
        sc = ($urandom_range(0, 19) == 0);
        qactive = qa; wake = wk; acc_n = an; deny_n = dn; scan = sc;
        eg = (m_state != 2) | sc;
        model_step(|qa, wk, an, dn);
        eq = (m_state == 0) || (m_state == 4) || (m_state == 5);
        ee = (m_state != 2);
        @(posedge clk); #1;
        chk("rnd.state", 8'(qstate), 8'(m_state));
        chk("rnd.qreqn", 8'(qreqn),  8'(eq));
        chk("rnd.clken", 8'(clk_en), 8'(ee));
        chk("rnd.perr",  8'(perr),   8'(m_err));
        chk("rnd.gclk",  8'(gclk),   8'(eg));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
